johnson_decoder: RTL and testbench

//  Receive end of a Johnson-code link. Samples a free-running N-stage Johnson count bus.

---
 rtl/johnson_dec_pkg.sv | 35 +++
 rtl/johnson_idx_decode.sv | 19 +
 rtl/johnson_decoder.sv | 161 ++++++++++++++++
 tb/tb_johnson_decoder.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/johnson_dec_pkg.sv
// Shared types and Johnson-code helpers for the johnson_decoder receive path.
// Helpers take the stage count as an argument so one package serves any N up to JC_MAX_N.
package johnson_dec_pkg;

    typedef enum logic [0:0] {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } jc_state_e;

    localparam int JC_MAX_N = 16;

    function automatic logic [JC_MAX_N-1:0] jc_mask(input int n);
        return (JC_MAX_N'(1) << n) - JC_MAX_N'(1);
    endfunction

    function automatic logic jc_top(input logic [JC_MAX_N-1:0] q, input int n);
        return ((q >> (n - 1)) & JC_MAX_N'(1)) != '0;
    endfunction

    // A legal code is a run of ones from bit 0 (top clear) or a run of zeros from bit 0 (top set).
    function automatic logic jc_is_legal(input logic [JC_MAX_N-1:0] q, input int n);
        logic [JC_MAX_N-1:0] m;
        logic [JC_MAX_N-1:0] v;
        m = jc_mask(n);
        v = jc_top(q, n) ? (~q & m) : (q & m);
        return (v & (v + JC_MAX_N'(1))) == '0;
    endfunction

    function automatic int jc_to_idx(input logic [JC_MAX_N-1:0] q, input int n);
        int pc;
        pc = $countones(q & jc_mask(n));
        return jc_top(q, n) ? (2 * n - pc) : pc;
    endfunction

endpackage

// File: rtl/johnson_idx_decode.sv
// Combinational Johnson code classifier: reports legality and the phase index 0..2N-1.
module johnson_idx_decode
    import johnson_dec_pkg::*;
#(
    parameter  int N  = 4,
    localparam int PW = $clog2(2 * N)
) (
    input  logic [N-1:0]  q,
    output logic          legal,
    output logic [PW-1:0] idx
);

    logic [JC_MAX_N-1:0] q_ext;

    assign q_ext = JC_MAX_N'(q);
    assign legal = jc_is_legal(q_ext, N);
    assign idx   = PW'(jc_to_idx(q_ext, N));

endmodule

// File: rtl/johnson_decoder.sv
// Johnson-code link receiver: decodes phase, tracks lock on successive steps, counts errors.
// Optional registered one-hot phase output when JOHNSON_DECODER_ONEHOT_EN is defined.
module johnson_decoder
    import johnson_dec_pkg::*;
#(
    parameter  int N          = 4,
    parameter  int LOCK_CNT   = 2,
    parameter  int ALLOW_HOLD = 0,
    parameter  int ERR_W      = 8,
    localparam int PW         = $clog2(2 * N)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             din_vld,
    input  logic [N-1:0]     din_q,
    input  logic             clr_err,
    output logic [PW-1:0]    phase,
    output logic             phase_vld,
    output logic             locked,
    output logic             err_ill,
    output logic             err_seq,
    output logic [ERR_W-1:0] err_cnt
`ifdef JOHNSON_DECODER_ONEHOT_EN
    ,
    output logic [2*N-1:0]   phase_oh
`endif
);

    localparam int NP   = 2 * N;
    localparam int MC_W = $clog2(LOCK_CNT + 1);

    logic            dec_legal;
    logic [PW-1:0]   dec_idx;

    jc_state_e       state_q,     state_d;
    logic [PW-1:0]   prev_idx_q,  prev_idx_d;
    logic            prev_vld_q,  prev_vld_d;
    logic [MC_W-1:0] match_cnt_q, match_cnt_d;
    logic [PW-1:0]   phase_q,     phase_d;
    logic            phase_vld_q, phase_vld_d;
    logic            err_ill_q,   err_ill_d;
    logic            err_seq_q,   err_seq_d;
    logic [ERR_W-1:0] err_cnt_q,  err_cnt_d;
    logic [NP-1:0]   phase_oh_q,  phase_oh_d;

    logic [PW-1:0]   succ_idx;
    logic            step_ok;

    johnson_idx_decode #(.N(N)) u_idx_decode (
        .q     (din_q),
        .legal (dec_legal),
        .idx   (dec_idx)
    );

    // Explicit wrap keeps the successor correct when 2N is not a power of two.
    assign succ_idx = (prev_idx_q == PW'(NP - 1)) ? '0 : prev_idx_q + PW'(1);
    assign step_ok  = prev_vld_q &&
                      ((dec_idx == succ_idx) || ((ALLOW_HOLD != 0) && (dec_idx == prev_idx_q)));

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        prev_idx_d  = prev_idx_q;
        prev_vld_d  = prev_vld_q;
        match_cnt_d = match_cnt_q;
        phase_d     = phase_q;
        phase_oh_d  = phase_oh_q;
        phase_vld_d = 1'b0;
        err_ill_d   = 1'b0;
        err_seq_d   = 1'b0;

        if (din_vld) begin
            if (!dec_legal) begin
                err_ill_d   = 1'b1;
                state_d     = SEARCH;
                match_cnt_d = '0;
                prev_vld_d  = 1'b0;
                phase_oh_d  = '0;
            end else begin
                phase_d     = dec_idx;
                phase_vld_d = 1'b1;
                phase_oh_d  = NP'(1) << dec_idx;
                prev_idx_d  = dec_idx;
                prev_vld_d  = 1'b1;
                case (state_q)
                    SEARCH: begin
                        if (!step_ok) begin
                            match_cnt_d = '0;
                        end else if (match_cnt_q == MC_W'(LOCK_CNT - 1)) begin
                            state_d     = LOCKED;
                            match_cnt_d = '0;
                        end else begin
                            match_cnt_d = match_cnt_q + MC_W'(1);
                        end
                    end
                    LOCKED: begin
                        if (!step_ok) begin
                            err_seq_d   = 1'b1;
                            state_d     = SEARCH;
                            match_cnt_d = '0;
                        end
                    end
                    default: begin
                        state_d     = SEARCH;
                        match_cnt_d = '0;
                    end
                endcase
            end
        end

        // Clear takes priority over an error arriving in the same cycle.
        err_cnt_d = err_cnt_q;
        if (clr_err) begin
            err_cnt_d = '0;
        end else if ((err_ill_d || err_seq_d) && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!reset) begin
            state_q     <= SEARCH;
            prev_idx_q  <= '0;
            prev_vld_q  <= 1'b0;
            match_cnt_q <= '0;
            phase_q     <= '0;
            phase_vld_q <= 1'b0;
            err_ill_q   <= 1'b0;
            err_seq_q   <= 1'b0;
            err_cnt_q   <= '0;
            phase_oh_q  <= '0;
        end else begin
            state_q     <= state_d;
            prev_idx_q  <= prev_idx_d;
            prev_vld_q  <= prev_vld_d;
            match_cnt_q <= match_cnt_d;
            phase_q     <= phase_d;
            phase_vld_q <= phase_vld_d;
            err_ill_q   <= err_ill_d;
            err_seq_q   <= err_seq_d;
            err_cnt_q   <= err_cnt_d;
            phase_oh_q  <= phase_oh_d;
        end
    end

    assign phase     = phase_q;
    assign phase_vld = phase_vld_q;
    assign locked    = (state_q == LOCKED);
    assign err_ill   = err_ill_q;
    assign err_seq   = err_seq_q;
    assign err_cnt   = err_cnt_q;

`ifdef JOHNSON_DECODER_ONEHOT_EN
    assign phase_oh = phase_oh_q;
`else
    logic unused_oh;
    assign unused_oh = ^phase_oh_q;
`endif

endmodule

// File: tb/tb_johnson_decoder.sv
// Self-checking bench for johnson_decoder: directed scenarios plus randomized traffic against
// a table-driven reference model; instance a has ALLOW_HOLD=0, instance b has ALLOW_HOLD=1.
module tb_johnson_decoder;

    localparam int N  = 4;
    localparam int NP = 2 * N;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       din_vld = 1'b0;
    logic [3:0] din_q = '0;
    logic       clr_err = 1'b0;

    logic [2:0] a_phase, b_phase;
    logic       a_phase_vld, b_phase_vld, a_locked, b_locked;
    logic       a_err_ill, b_err_ill, a_err_seq, b_err_seq;
    logic [7:0] a_err_cnt, b_err_cnt;
`ifdef JOHNSON_DECODER_ONEHOT_EN
    logic [7:0] a_phase_oh, b_phase_oh;
`endif

    int checks = 0;
    int errors = 0;

    logic [3:0] codes [NP];

    int         m_prev [2];
    bit         m_have [2];
    int         m_run  [2];
    bit         m_lock [2];
    int         m_phase[2];
    bit         m_pv   [2];
    bit         m_ill  [2];
    bit         m_seq  [2];
    int         m_cnt  [2];
    logic [7:0] m_oh;

    always #5 clock = ~clock;

    johnson_decoder #(.N(N), .LOCK_CNT(2), .ALLOW_HOLD(0), .ERR_W(8)) dut_a (
        .clock(clock), .reset(reset), .din_vld(din_vld), .din_q(din_q), .clr_err(clr_err),
        .phase(a_phase), .phase_vld(a_phase_vld), .locked(a_locked),
        .err_ill(a_err_ill), .err_seq(a_err_seq), .err_cnt(a_err_cnt)
`ifdef JOHNSON_DECODER_ONEHOT_EN
        , .phase_oh(a_phase_oh)
`endif
    );

    johnson_decoder #(.N(N), .LOCK_CNT(2), .ALLOW_HOLD(1), .ERR_W(8)) dut_b (
        .clock(clock), .reset(reset), .din_vld(din_vld), .din_q(din_q), .clr_err(clr_err),
        .phase(b_phase), .phase_vld(b_phase_vld), .locked(b_locked),
        .err_ill(b_err_ill), .err_seq(b_err_seq), .err_cnt(b_err_cnt)
`ifdef JOHNSON_DECODER_ONEHOT_EN
        , .phase_oh(b_phase_oh)
`endif
    );

    function automatic int code_to_idx(input logic [3:0] d);
        for (int i = 0; i < NP; i++) if (codes[i] === d) return i;
        return -1;
    endfunction

    task automatic model_step(input bit rst, input bit vld, input logic [3:0] d, input bit clr);
        int  idx;
        bit  ok;
        idx = code_to_idx(d);
        if (rst) m_oh = '0;
        else if (vld && idx < 0) m_oh = '0;
        else if (vld) m_oh = 8'(1) << idx;
        for (int h = 0; h < 2; h++) begin
            if (rst) begin
                m_lock[h] = 0; m_have[h] = 0; m_run[h] = 0; m_prev[h] = 0; m_phase[h] = 0;
                m_pv[h] = 0; m_ill[h] = 0; m_seq[h] = 0; m_cnt[h] = 0;
                continue;
            end
            m_pv[h] = 0; m_ill[h] = 0; m_seq[h] = 0;
            if (vld) begin
                if (idx < 0) begin
                    m_ill[h] = 1; m_lock[h] = 0; m_run[h] = 0; m_have[h] = 0;
                end else begin
                    ok = m_have[h] && ((idx == (m_prev[h] + 1) % NP) || (h == 1 && idx == m_prev[h]));
                    m_pv[h] = 1; m_phase[h] = idx;
                    if (m_lock[h]) begin
                        if (!ok) begin m_seq[h] = 1; m_lock[h] = 0; m_run[h] = 0; end
                    end else if (ok) begin
                        m_run[h]++;
                        if (m_run[h] >= 2) begin m_lock[h] = 1; m_run[h] = 0; end
                    end else begin
                        m_run[h] = 0;
                    end
                    m_prev[h] = idx; m_have[h] = 1;
                end
            end
            if (clr) m_cnt[h] = 0;
            else if ((m_ill[h] || m_seq[h]) && m_cnt[h] < 255) m_cnt[h]++;
        end
    endtask

    task automatic tick(input bit vld, input logic [3:0] d, input bit clr);
        din_vld = vld; din_q = d; clr_err = clr;
        @(posedge clock);
        model_step(!reset, vld, d, clr);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(0, 4'b0000, 0);
        reset = 1'b1;
    endtask

    task automatic lock_at_two();
        do_reset();
        tick(1, 4'b0000, 0); tick(1, 4'b0001, 0); tick(1, 4'b0011, 0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({a_phase, a_phase_vld, a_locked, a_err_ill, a_err_seq, a_err_cnt} !== '0) begin
            errors++; $display("FAIL reset_state got phase=%0d vld=%b lock=%b ill=%b seq=%b cnt=%0d exp all 0",
                               a_phase, a_phase_vld, a_locked, a_err_ill, a_err_seq, a_err_cnt);
        end
    endtask

    task automatic test_sequence();
        logic [3:0] seq [9] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                4'b1110, 4'b1100, 4'b1000, 4'b0000};
        do_reset();
        for (int k = 0; k < 9; k++) begin
            tick(1, seq[k], 0);
            checks++;
            if (a_phase !== 3'(k % 8) || a_phase_vld !== 1'b1) begin
                errors++; $display("FAIL seq_phase k=%0d got %0d/%b exp %0d/1", k, a_phase, a_phase_vld, k % 8);
            end
            checks++;
            if (a_locked !== (k >= 2)) begin
                errors++; $display("FAIL seq_locked k=%0d got %b exp %b", k, a_locked, (k >= 2));
            end
            checks++;
            if ({a_err_ill, a_err_seq, a_err_cnt} !== '0) begin
                errors++; $display("FAIL seq_noerr k=%0d got ill=%b seq=%b cnt=%0d exp 0", k, a_err_ill, a_err_seq, a_err_cnt);
            end
`ifdef JOHNSON_DECODER_ONEHOT_EN
            checks++;
            if (a_phase_oh !== (8'h01 << (k % 8))) begin
                errors++; $display("FAIL seq_onehot k=%0d got %h exp %h", k, a_phase_oh, 8'h01 << (k % 8));
            end
`endif
        end
    endtask

    task automatic test_illegal();
        lock_at_two();
        tick(1, 4'b0101, 0);
        checks++;
        if ({a_err_ill, a_locked, a_phase_vld, a_phase, a_err_cnt} !== {1'b1, 1'b0, 1'b0, 3'd2, 8'd1}) begin
            errors++; $display("FAIL illegal_inject got ill=%b lock=%b vld=%b phase=%0d cnt=%0d exp 1 0 0 2 1",
                               a_err_ill, a_locked, a_phase_vld, a_phase, a_err_cnt);
        end
        tick(0, 4'b0000, 0);
        checks++;
        if ({a_err_ill, a_err_cnt, a_phase} !== {1'b0, 8'd1, 3'd2}) begin
            errors++; $display("FAIL illegal_after got ill=%b cnt=%0d phase=%0d exp 0 1 2", a_err_ill, a_err_cnt, a_phase);
        end
    endtask

    task automatic test_seq_err();
        lock_at_two();
        tick(1, 4'b0111, 0);
        tick(1, 4'b1100, 0);
        checks++;
        if ({a_err_seq, a_err_ill, a_phase, a_locked, a_err_cnt} !== {1'b1, 1'b0, 3'd6, 1'b0, 8'd1}) begin
            errors++; $display("FAIL seqerr_inject got seq=%b ill=%b phase=%0d lock=%b cnt=%0d exp 1 0 6 0 1",
                               a_err_seq, a_err_ill, a_phase, a_locked, a_err_cnt);
        end
        tick(1, 4'b1000, 0);
        checks++;
        if ({a_locked, a_err_seq, a_phase} !== {1'b0, 1'b0, 3'd7}) begin
            errors++; $display("FAIL seqerr_step1 got lock=%b seq=%b phase=%0d exp 0 0 7", a_locked, a_err_seq, a_phase);
        end
        tick(1, 4'b0000, 0);
        checks++;
        if ({a_locked, a_phase} !== {1'b1, 3'd0}) begin
            errors++; $display("FAIL seqerr_relock got lock=%b phase=%0d exp 1 0", a_locked, a_phase);
        end
    endtask

    task automatic test_hold();
        lock_at_two();
        for (int k = 0; k < 5; k++) begin
            tick(0, 4'($urandom_range(0, 15)), 0);
            checks++;
            if ({a_phase_vld, a_err_ill, a_err_seq, a_locked, a_phase, b_phase_vld, b_locked} !==
                {1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1}) begin
                errors++; $display("FAIL idle_hold k=%0d got vld=%b ill=%b seq=%b lock=%b phase=%0d exp 0 0 0 1 2",
                                   k, a_phase_vld, a_err_ill, a_err_seq, a_locked, a_phase);
            end
        end
        tick(1, 4'b0011, 0);
        checks++;
        if ({a_err_seq, a_locked, a_phase_vld, a_phase} !== {1'b1, 1'b0, 1'b1, 3'd2}) begin
            errors++; $display("FAIL repeat_nohold got seq=%b lock=%b vld=%b phase=%0d exp 1 0 1 2",
                               a_err_seq, a_locked, a_phase_vld, a_phase);
        end
        checks++;
        if ({b_err_seq, b_locked, b_err_cnt} !== {1'b0, 1'b1, 8'd0}) begin
            errors++; $display("FAIL repeat_hold got seq=%b lock=%b cnt=%0d exp 0 1 0", b_err_seq, b_locked, b_err_cnt);
        end
    endtask

    task automatic test_saturate();
        logic [3:0] bad [4] = '{4'b0101, 4'b1010, 4'b0010, 4'b1101};
        do_reset();
        for (int k = 0; k < 300; k++) tick(1, bad[$urandom_range(0, 3)], 0);
        checks++;
        if (a_err_cnt !== 8'd255 || b_err_cnt !== 8'd255) begin
            errors++; $display("FAIL saturate got %0d/%0d exp 255", a_err_cnt, b_err_cnt);
        end
        tick(1, 4'b0101, 1);
        checks++;
        if ({a_err_cnt, a_err_ill} !== {8'd0, 1'b1}) begin
            errors++; $display("FAIL clr_wins got cnt=%0d ill=%b exp 0 1", a_err_cnt, a_err_ill);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        tick(1, 4'b0101, 0);
        tick(1, 4'b0000, 0); tick(1, 4'b0001, 0); tick(1, 4'b0011, 0); tick(1, 4'b0111, 0);
        reset = 1'b0;
        tick(1, 4'b1111, 0);
        reset = 1'b1;
        checks++;
        if ({a_phase, a_phase_vld, a_locked, a_err_ill, a_err_seq, a_err_cnt} !== '0) begin
            errors++; $display("FAIL reset_mid got phase=%0d vld=%b lock=%b ill=%b seq=%b cnt=%0d exp all 0",
                               a_phase, a_phase_vld, a_locked, a_err_ill, a_err_seq, a_err_cnt);
        end
`ifdef JOHNSON_DECODER_ONEHOT_EN
        checks++;
        if (a_phase_oh !== 8'h00) begin
            errors++; $display("FAIL reset_mid_onehot got %h exp 00", a_phase_oh);
        end
`endif
    endtask

    task automatic test_random();
        int ci = 0;
        int r;
        logic [15:0] obs, exp;
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            r = $urandom_range(0, 99);
            if (r < 55) begin ci = (ci + 1) % NP; tick(1, codes[ci], 0); end
            else if (r < 63) tick(1, codes[ci], 0);
            else if (r < 71) begin ci = $urandom_range(0, NP - 1); tick(1, codes[ci], 0); end
            else if (r < 79) tick(1, 4'($urandom_range(0, 15)), 0);
            else if (r < 95) tick(0, 4'($urandom_range(0, 15)), 0);
            else if (r < 99) tick(1'($urandom_range(0, 1)), codes[ci], 1);
            else begin reset = 1'b0; tick(1, codes[ci], 0); reset = 1'b1; end
            obs = {a_phase, a_phase_vld, a_locked, a_err_ill, a_err_seq, a_err_cnt};
            exp = {3'(m_phase[0]), m_pv[0], m_lock[0], m_ill[0], m_seq[0], 8'(m_cnt[0])};
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL rand_a k=%0d got %h exp %h", k, obs, exp);
            end
            obs = {b_phase, b_phase_vld, b_locked, b_err_ill, b_err_seq, b_err_cnt};
            exp = {3'(m_phase[1]), m_pv[1], m_lock[1], m_ill[1], m_seq[1], 8'(m_cnt[1])};
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL rand_b k=%0d got %h exp %h", k, obs, exp);
            end
`ifdef JOHNSON_DECODER_ONEHOT_EN
            checks++;
            if (a_phase_oh !== m_oh || b_phase_oh !== m_oh) begin
                errors++; $display("FAIL rand_onehot k=%0d got %h/%h exp %h", k, a_phase_oh, b_phase_oh, m_oh);
            end
`endif
        end
    endtask

    initial begin
        logic [3:0] c;
        c = 4'b0000;
        for (int i = 0; i < NP; i++) begin
            codes[i] = c;
            c = {c[2:0], ~c[3]};
        end
        model_step(1, 0, 4'b0000, 0);
        test_reset();
        test_sequence();
        test_illegal();
        test_seq_err();
        test_hold();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
